// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly with twiddle rotation,
// optional halving and range limiting, and a valid/ready handshake.
// The whole pipeline shares one stall enable, so backpressure freezes every stage.
// Optional build macro BUTTERFLY_PIPE_SAT_EN: when defined, out-of-range
// results saturate to the nearest limit; when undefined, the results wrap.
module butterfly_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [1:0][DATA_WIDTH-1:0]  a_i,
    input  logic [1:0][DATA_WIDTH-1:0]  b_i,
    input  logic [1:0][FRAC_BITS:0]     twid_i,
    input  logic                        inv_i,
    input  logic                        scale_i,
    input  logic [TAG_WIDTH-1:0]        tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0]  a_o,
    output logic [1:0][DATA_WIDTH-1:0]  b_o,
    output logic [TAG_WIDTH-1:0]        tag_o,
    output logic                        ovf_o,
    input  logic                        ovf_clr_i
);

    localparam int PW = DATA_WIDTH + FRAC_BITS + 1;  // full product width
    localparam int SW = PW + 1;                      // rotation sum width
    localparam int RW = DATA_WIDTH + 2;              // rounded / add-sub width

    localparam logic [SW-1:0] RND = {{(SW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    logic en;
    assign en = !out_valid_o || out_ready_i;
    // Reset forces ready high even while a stalled result is still held.
    assign in_ready_o = en || !rst_ni;

    // Operands sign-extended to the product width; the low PW bits of the
    // unsigned product equal the signed product.
    logic [PW-1:0] br_x, bi_x, wr_x, wi_x;
    assign br_x = {{(PW-DATA_WIDTH){b_i[0][DATA_WIDTH-1]}}, b_i[0]};
    assign bi_x = {{(PW-DATA_WIDTH){b_i[1][DATA_WIDTH-1]}}, b_i[1]};
    assign wr_x = {{(PW-FRAC_BITS-1){twid_i[0][FRAC_BITS]}}, twid_i[0]};
    assign wi_x = {{(PW-FRAC_BITS-1){twid_i[1][FRAC_BITS]}}, twid_i[1]};

    logic                       v1, inv1, scale1;
    logic [1:0][DATA_WIDTH-1:0] a1;
    logic [PW-1:0]              p_rr1, p_ii1, p_ri1, p_ir1;
    logic [TAG_WIDTH-1:0]       tag1;

    // Stage 1: register the four partial products with their sideband.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1     <= in_valid_i;
            a1     <= a_i;
            p_rr1  <= br_x * wr_x;
            p_ii1  <= bi_x * wi_x;
            p_ri1  <= br_x * wi_x;
            p_ir1  <= bi_x * wr_x;
            inv1   <= inv_i;
            scale1 <= scale_i;
            tag1   <= tag_i;
        end
    end

    logic [SW-1:0] rr_x, ii_x, ri_x, ir_x, sum_re, sum_im, rnd_re, rnd_im;
    assign rr_x = {p_rr1[PW-1], p_rr1};
    assign ii_x = {p_ii1[PW-1], p_ii1};
    assign ri_x = {p_ri1[PW-1], p_ri1};
    assign ir_x = {p_ir1[PW-1], p_ir1};

    // Rotation by W or conj(W), rounded half-up at the fraction boundary.
    always_comb begin
        sum_re = inv1 ? (rr_x + ii_x) : (rr_x - ii_x);
        sum_im = inv1 ? (ir_x - ri_x) : (ri_x + ir_x);
        rnd_re = sum_re + RND;
        rnd_im = sum_im + RND;
    end

    logic                       v2, scale2;
    logic [1:0][DATA_WIDTH-1:0] a2;
    logic [RW-1:0]              rot2_re, rot2_im;
    logic [TAG_WIDTH-1:0]       tag2;

    // Stage 2: register the rounded rotation (arithmetic shift == upper slice).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v2 <= 1'b0;
        end else if (en) begin
            v2      <= v1;
            a2      <= a1;
            rot2_re <= rnd_re[SW-1:FRAC_BITS];
            rot2_im <= rnd_im[SW-1:FRAC_BITS];
            scale2  <= scale1;
            tag2    <= tag1;
        end
    end

    function automatic logic [RW-1:0] halve(input logic [RW-1:0] v, input logic s);
        return s ? {v[RW-1], v[RW-1:1]} : v;
    endfunction

    function automatic logic out_of_range(input logic [RW-1:0] v);
        return !((&v[RW-1:DATA_WIDTH-1]) || !(|v[RW-1:DATA_WIDTH-1]));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] limit(input logic [RW-1:0] v);
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (out_of_range(v))
            return v[RW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
        return v[DATA_WIDTH-1:0];
    endfunction

    logic [RW-1:0] ax_re, ax_im, s_are, s_aim, s_bre, s_bim;
    logic          ovf_d;

    // Stage 3: add/subtract, optional halving and overflow detection.
    always_comb begin
        ax_re = {{2{a2[0][DATA_WIDTH-1]}}, a2[0]};
        ax_im = {{2{a2[1][DATA_WIDTH-1]}}, a2[1]};
        s_are = halve(ax_re + rot2_re, scale2);
        s_aim = halve(ax_im + rot2_im, scale2);
        s_bre = halve(ax_re - rot2_re, scale2);
        s_bim = halve(ax_im - rot2_im, scale2);
        ovf_d = out_of_range(s_are) || out_of_range(s_aim) ||
                out_of_range(s_bre) || out_of_range(s_bim);
    end

    // Output register: holds its contents whenever the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            a_o         <= '0;
            b_o         <= '0;
            tag_o       <= '0;
        end else if (en) begin
            out_valid_o <= v2;
            if (v2) begin
                a_o   <= {limit(s_aim), limit(s_are)};
                b_o   <= {limit(s_bim), limit(s_bre)};
                tag_o <= tag2;
            end
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            ovf_o <= 1'b0;
        else if (en && v2 && ovf_d)
            ovf_o <= 1'b1;
        else if (ovf_clr_i)
            ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (DATA_WIDTH=16, FRAC_BITS=15).
module tb_butterfly_pipe;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0][15:0] a_i, b_i;
    logic [1:0][15:0] twid_i;
    logic             inv_i, scale_i;
    logic [7:0]       tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [1:0][15:0] a_o, b_o;
    logic [7:0]       tag_o;
    logic             ovf_o;
    logic             ovf_clr_i;

    int tests = 0;
    int fails = 0;

`ifdef BUTTERFLY_PIPE_SAT_EN
    localparam logic [15:0] OVF_ARE = 16'h7FFF;
`else
    localparam logic [15:0] OVF_ARE = 16'hDFFF;
`endif

    butterfly_pipe #(.DATA_WIDTH(16), .FRAC_BITS(15), .TAG_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .twid_i(twid_i),
        .inv_i(inv_i), .scale_i(scale_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .a_o(a_o), .b_o(b_o), .tag_o(tag_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [15:0] ar, ai, br, bi, wr, wi,
                         input logic inv, sc, input logic [7:0] tg);
        a_i = {ai, ar};
        b_i = {bi, br};
        twid_i = {wi, wr};
        inv_i = inv;
        scale_i = sc;
        tag_i = tg;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; ovf_clr_i = 1'b0;
        drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 8'h0);
        tick();
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL rst_in_ready_during: got %b expected 1", in_ready_o); end
        tick();
        rst_ni = 1'b1;
        #1;
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid_o); end
        tests++; if (a_o !== 32'h0) begin fails++; $display("FAIL rst_a_o: got %h expected 0", a_o); end
        tests++; if (b_o !== 32'h0) begin fails++; $display("FAIL rst_b_o: got %h expected 0", b_o); end
        tests++; if (tag_o !== 8'h0) begin fails++; $display("FAIL rst_tag_o: got %h expected 0", tag_o); end
        tests++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b expected 0", ovf_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL rst_in_ready_after: got %b expected 1", in_ready_o); end
    endtask

    task automatic test_basic();
        drive(16'h1000, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b1, 8'h11);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL basic_lat1: got %b expected 0", out_valid_o); end
        tick();
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL basic_lat2: got %b expected 0", out_valid_o); end
        tick();
        tests++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL basic_lat3: got %b expected 1", out_valid_o); end
        tests++; if (a_o !== {16'h0000, 16'h2800}) begin fails++; $display("FAIL basic_a_o: got %h expected 00002800", a_o); end
        tests++; if (b_o !== {16'h0000, 16'hE800}) begin fails++; $display("FAIL basic_b_o: got %h expected 0000e800", b_o); end
        tests++; if (tag_o !== 8'h11) begin fails++; $display("FAIL basic_tag: got %h expected 11", tag_o); end
        tests++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b expected 0", ovf_o); end
        tick();
    endtask

    task automatic test_inv();
        drive(16'h0, 16'h0, 16'h2000, 16'h0, 16'h0, 16'h8000, 1'b0, 1'b0, 8'h01);
        in_valid_i = 1'b1;
        tick();
        drive(16'h0, 16'h0, 16'h2000, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b0, 8'h02);
        tick();
        in_valid_i = 1'b0;
        tick();
        tests++; if (out_valid_o !== 1'b1 || tag_o !== 8'h01) begin fails++; $display("FAIL inv0_valid_tag: got %b/%h expected 1/01", out_valid_o, tag_o); end
        tests++; if (a_o !== {16'hE000, 16'h0000}) begin fails++; $display("FAIL inv0_a_o: got %h expected e0000000", a_o); end
        tests++; if (b_o !== {16'h2000, 16'h0000}) begin fails++; $display("FAIL inv0_b_o: got %h expected 20000000", b_o); end
        tick();
        tests++; if (out_valid_o !== 1'b1 || tag_o !== 8'h02) begin fails++; $display("FAIL inv1_valid_tag: got %b/%h expected 1/02", out_valid_o, tag_o); end
        tests++; if (a_o !== {16'h2000, 16'h0000}) begin fails++; $display("FAIL inv1_a_o: got %h expected 20000000", a_o); end
        tests++; if (b_o !== {16'hE000, 16'h0000}) begin fails++; $display("FAIL inv1_b_o: got %h expected e0000000", b_o); end
        tick();
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL inv_drain: got %b expected 0", out_valid_o); end
    endtask

    task automatic test_overflow();
        drive(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0, 8'h33);
        ovf_clr_i = 1'b1;            // held through the edge that sets the flag
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        ovf_clr_i = 1'b0;
        tests++; if (a_o !== {16'h0000, OVF_ARE}) begin fails++; $display("FAIL ovf_a_o: got %h expected 0000%h", a_o, OVF_ARE); end
        tests++; if (b_o !== {16'h0000, 16'h0001}) begin fails++; $display("FAIL ovf_b_o: got %h expected 00000001", b_o); end
        tests++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b expected 1", ovf_o); end
        tick(); tick(); tick();
        tests++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", ovf_o); end
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        tests++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", ovf_o); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recvd = 0;
        int stalls = 0;
        logic stalled_prev = 1'b0;
        logic [1:0][15:0] prev_a;
        logic [7:0] prev_tag;
        logic [15:0] er, ei;
        for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
            in_valid_i = (sent < 8);
            drive(16'(sent) * 16'h0101, 16'(sent) + 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0,
                  1'b0, 1'b0, 8'(sent));
            out_ready_i = !(cyc >= 4 && cyc <= 8);
            #1;
            if (stalled_prev) begin
                tests++;
                if (out_valid_o !== 1'b1 || tag_o !== prev_tag || a_o !== prev_a) begin
                    fails++;
                    $display("FAIL b2b_stable: got %b/%h/%h expected 1/%h/%h", out_valid_o, tag_o, a_o, prev_tag, prev_a);
                end
            end
            if (out_valid_o && !out_ready_i) begin
                stalls++;
                tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_in_ready: got %b expected 0 (cycle %0d)", in_ready_o, cyc); end
            end
            if (out_valid_o && out_ready_i) begin
                er = 16'(recvd) * 16'h0101;
                ei = 16'(recvd) + 16'h0040;
                tests++; if (tag_o !== 8'(recvd)) begin fails++; $display("FAIL b2b_tag: got %h expected %h", tag_o, 8'(recvd)); end
                tests++; if (a_o !== {ei, er} || b_o !== {ei, er}) begin fails++; $display("FAIL b2b_data: got %h/%h expected %h", a_o, b_o, {ei, er}); end
                recvd++;
            end
            prev_a = a_o;
            prev_tag = tag_o;
            stalled_prev = out_valid_o && !out_ready_i;
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        tests++; if (recvd != 8) begin fails++; $display("FAIL b2b_count: got %0d expected 8", recvd); end
        tests++; if (stalls != 5) begin fails++; $display("FAIL b2b_stalls: got %0d expected 5", stalls); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_extra: got %b expected 0 (tag %h)", out_valid_o, tag_o); end
            tick();
        end
    endtask

    task automatic test_reset_flight();
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0, 8'(8'hA0 + k));
            in_valid_i = 1'b1;
            tick();
        end
        in_valid_i = 1'b0;
        tests++; if (out_valid_o !== 1'b1 || tag_o !== 8'hA0) begin fails++; $display("FAIL flight_full: got %b/%h expected 1/a0", out_valid_o, tag_o); end
        tests++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL flight_ovf_pre: got %b expected 1", ovf_o); end
        rst_ni = 1'b0;
        #1;
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL flight_ready_in_rst: got %b expected 1", in_ready_o); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        #1;
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flight_valid_cleared: got %b expected 0", out_valid_o); end
        tests++; if (ovf_o !== 1'b0 || tag_o !== 8'h0) begin fails++; $display("FAIL flight_state_cleared: got %b/%h expected 0/00", ovf_o, tag_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL flight_ready_after: got %b expected 1", in_ready_o); end
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flight_stale: got %b expected 0 (tag %h)", out_valid_o, tag_o); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inv();
        test_overflow();
        test_back_to_back();
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed width of each real/imag data component.
REQ-002 SHALL have parameter FRAC_BITS, default 15, meaning twiddle fraction bits; twiddle component width is FRAC_BITS+1, Q1.FRAC_BITS signed.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, meaning width of sideband tag carried alongside data.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have in_valid_i input 1 and in_ready_o output 1, meaning input handshake.
REQ-007 SHALL have a_i, b_i input [1:0][DATA_WIDTH-1:0], meaning operands; index 0 real, 1 imag.
REQ-008 SHALL have twid_i input [1:0][FRAC_BITS:0], meaning twiddle W; index 0 real, 1 imag.
REQ-009 SHALL have inv_i input 1 (1 = use conj(W)), scale_i input 1 (1 = halve outputs), tag_i input TAG_WIDTH.
REQ-010 SHALL have out_valid_o output 1 and out_ready_i input 1, meaning output handshake.
REQ-011 SHALL have a_o, b_o output [1:0][DATA_WIDTH-1:0] and tag_o output TAG_WIDTH, meaning results and tag.
REQ-012 SHALL have ovf_o output 1 (sticky overflow) and ovf_clr_i input 1 (clear sticky flag).

Function
REQ-013 SHALL transfer input when in_valid_i && in_ready_o; output when out_valid_o && out_ready_i.
REQ-014 SHALL be a 3-stage pipeline: S1 four products, S2 rotation sum and rounding, S3 add/sub, scale, range limit; latency exactly 3 cycles with out_ready_i held high.
REQ-015 SHALL use global stall enable en = !out_valid_o || out_ready_i; in_ready_o = en; all stages advance only when en=1; bubbles propagate as invalid.
REQ-016 SHALL sustain one transaction per cycle with out_ready_i high; no data loss, duplication or reordering under any backpressure pattern.
REQ-017 SHALL keep a_o, b_o, tag_o, out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-018 SHALL compute rot_re = br*wr - bi*wi, rot_im = br*wi + bi*wr when inv=0; rot_re = br*wr + bi*wi, rot_im = bi*wr - br*wi when inv=1; full-precision, no intermediate overflow.
REQ-019 SHALL round rotation as (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, held in DATA_WIDTH+2 bits.
REQ-020 SHALL compute a_o = a + rot and b_o = a - rot per component in DATA_WIDTH+2 bits.
REQ-021 SHALL, when scale=1, arithmetic-shift sums right by 1 (floor); scale=0, no shift.
REQ-022 SHALL flag overflow when any of the four scaled results is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-023 SHALL set ovf_o on the cycle after an overflowing transaction leaves S3 into the output register; ovf_o holds until ovf_clr_i=1; simultaneous set and clear leaves ovf_o=1.
REQ-024 SHALL carry inv_i, scale_i, tag_i per transaction through the pipeline aligned to its data.

Reset
REQ-025 SHALL, when rst_ni=0 at a clock edge, clear all stage valids, out_valid_o=0, ovf_o=0, a_o=b_o=0, tag_o=0.
REQ-026 SHALL discard all in-flight transactions on reset mid-operation; in_ready_o=1 during reset and the first cycle after.

Configuration
REQ-027 SHALL, with BUTTERFLY_PIPE_SAT_EN defined, saturate out-of-range results to the nearest limit (0x7FFF/0x8000 at width 16).
REQ-028 SHALL, without BUTTERFLY_PIPE_SAT_EN, wrap results (keep low DATA_WIDTH bits); ovf_o behaves identically in both builds.

Verification (DATA_WIDTH=16, FRAC_BITS=15)
REQ-029 SHALL cover: a=(0x1000,0), b=(0x4000,0), W=(0x7FFF,0), inv=0, scale=1 -> after 3 cycles a_o=(0x2800,0), b_o=(0xE800,0), ovf_o=0.
REQ-030 SHALL cover: a=(0,0), b=(0x2000,0), W=(0,0x8000), scale=0 -> inv=0 a_o=(0,0xE000); inv=1 a_o=(0,0x2000), b_o=(0,0xE000).
REQ-031 SHALL cover: a=b=(0x7000,0), W=(0x7FFF,0), scale=0 -> a_o re 0x7FFF with macro, 0xDFFF without; b_o re 0x0001; ovf_o=1 until ovf_clr_i pulse.
REQ-032 SHALL cover: 8 back-to-back inputs tags 0..7, out_ready_i low cycles 4-8 -> in_ready_o low while stalled, outputs stable, tags 0..7 emerge in order, none lost.
REQ-033 SHALL cover: rst_ni low 1 cycle with 3 transactions in flight -> out_valid_o=0 next cycle, no stale output appears afterwards.
